// File: rtl/fsm_pkg.sv
// Shared state encoding and default stall budget for the burst read controller.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  localparam int DEF_MAX_WAIT = 7;

endpackage

// File: rtl/stall_timer.sv
// Counts consecutive stall cycles of one beat; expired flags the stall that
// arrives once the tolerated budget has already been spent.
module stall_timer
  import fsm_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic stall,
  output logic expired
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = stall && (count_q == CNT_W'(MAX_WAIT));

  // Saturate at MAX_WAIT; the FSM leaves READ on the expiring cycle anyway.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (stall && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/burst_rd_fsm.sv
// Moore read-burst controller: one go request reads burst_len+1 consecutive
// addresses, honouring memory wait states with a bounded stall timeout.
module burst_rd_fsm
  import fsm_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              ws,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              ds,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for go; addr holds the last beat address
  // READ  | rd asserted; advance on ws=0, count stall cycles on ws=1
  // DONE  | one-cycle done strobe after the last accepted beat
  // ERR   | one-cycle error strobe after a stall timeout

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              in_read;
  logic              stall_expired;

  assign in_read = (state_q == READ);

  stall_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_stall_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_read || !ws),
    .stall   (in_read && ws),
    .expired (stall_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = READ;
          addr_d  = start_addr;
          beat_d  = burst_len;
        end
      end
      READ: begin
        if (!ws) begin
          if (beat_q == '0) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            beat_d = beat_q - LEN_W'(1);
          end
        end else if (stall_expired) begin
          state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd   = 1'b0;
    ds   = 1'b0;
    err  = 1'b0;
    busy = 1'b1;
    case (state_q)
      IDLE:    busy = 1'b0;
      READ:    rd   = 1'b1;
      DONE:    ds   = 1'b1;
      default: err  = 1'b1;
    endcase
  end

  assign addr = addr_q;

endmodule

// File: tb/tb_burst_rd_fsm.sv
// Self-checking bench for burst_rd_fsm: expected per-cycle outputs are queued
// as each cycle's inputs are driven and compared after the following edge.
module tb_burst_rd_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [7:0] start_addr;
  logic [3:0] burst_len;
  logic       ws;
  logic       rd;
  logic [7:0] addr;
  logic       busy;
  logic       ds;
  logic       err;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic       ds;
    logic       err;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  burst_rd_fsm #(
    .ADDR_W   (8),
    .LEN_W    (4),
    .MAX_WAIT (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .ws         (ws),
    .rd         (rd),
    .addr       (addr),
    .busy       (busy),
    .ds         (ds),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic r, input logic [7:0] a, input logic d,
                              input logic e, input logic b);
    exp_t x;
    x.rd = r; x.addr = a; x.ds = d; x.err = e; x.busy = b;
    return x;
  endfunction

  // Drive one cycle of inputs (called at a falling edge) and queue the
  // outputs expected after the next rising edge.
  task automatic step(input logic g, input logic [7:0] sa, input logic [3:0] bl,
                      input logic w, input exp_t e);
    go = g; start_addr = sa; burst_len = bl; ws = w;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // One burst from IDLE. stall_beat < 0 means no stalls; stall_len > 7 times out.
  // noise=1 keeps go high with a different start address for the whole burst.
  task automatic burst(input logic [7:0] sa, input logic [3:0] bl, input int stall_beat,
                       input int stall_len, input logic noise);
    logic [7:0] a;
    logic [7:0] other;
    other = sa ^ 8'hA5;
    step(1'b1, sa, bl, 1'b0, mk(1'b1, sa, 1'b0, 1'b0, 1'b1));
    for (int b = 0; b <= int'(bl); b++) begin
      a = sa + 8'(b);
      if (b == stall_beat) begin
        for (int k = 0; k < stall_len; k++) begin
          if (k < 7) begin
            step(noise, other, 4'hF, 1'b1, mk(1'b1, a, 1'b0, 1'b0, 1'b1));
          end else begin
            step(noise, other, 4'hF, 1'b1, mk(1'b0, a, 1'b0, 1'b1, 1'b1));
            step(noise, other, 4'hF, 1'b0, mk(1'b0, a, 1'b0, 1'b0, 1'b0));
            return;
          end
        end
      end
      if (b < int'(bl)) begin
        step(noise, other, 4'hF, 1'b0, mk(1'b1, a + 8'd1, 1'b0, 1'b0, 1'b1));
      end else begin
        step(noise, other, 4'hF, 1'b0, mk(1'b0, a, 1'b1, 1'b0, 1'b1));
      end
    end
    step(noise, other, 4'hF, 1'b1, mk(1'b0, sa + 8'(bl), 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd",   32'(rd),   32'(e.rd));
        check("addr", 32'(addr), 32'(e.addr));
        check("ds",   32'(ds),   32'(e.ds));
        check("err",  32'(err),  32'(e.err));
        check("busy", 32'(busy), 32'(e.busy));
      end
    end
  end

  initial begin
    rst = 1'b1; go = 1'b0; start_addr = '0; burst_len = '0; ws = 1'b0;
    @(negedge clk);
    step(1'b1, 8'h55, 4'd3, 1'b0, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    step(1'b0, 8'h55, 4'd3, 1'b0, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));

    burst(8'h10, 4'd3, -1, 0, 1'b0);
    burst(8'h10, 4'd3, 1, 2, 1'b0);
    burst(8'h40, 4'd2, 0, 8, 1'b0);
    burst(8'hFE, 4'd3, -1, 0, 1'b0);
    burst(8'h30, 4'd1, -1, 0, 1'b1);
    burst(8'h60, 4'd0, -1, 0, 1'b1);
    burst(8'h80, 4'd15, 2, 7, 1'b0);

    // Reset on beat 2 of a 4-beat burst, then a clean burst.
    step(1'b1, 8'h20, 4'd3, 1'b0, mk(1'b1, 8'h20, 1'b0, 1'b0, 1'b1));
    step(1'b0, 8'h20, 4'd3, 1'b0, mk(1'b1, 8'h21, 1'b0, 1'b0, 1'b1));
    rst = 1'b1;
    step(1'b0, 8'h20, 4'd3, 1'b0, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    step(1'b0, 8'h20, 4'd3, 1'b0, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    burst(8'h05, 4'd2, -1, 0, 1'b0);

    @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
